// File: rtl/alu_seq.sv
// alu_seq: handshaked multi-cycle ALU with iterative shifts and zero/carry/overflow flags.
// Define ALU_SEQ_MUL_EN to build the iterative multiplier for opcode 11; otherwise it decodes as illegal.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       op_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             illegal
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] OP_NOT = 4'd0;
  localparam logic [3:0] OP_AND = 4'd1;
  localparam logic [3:0] OP_XOR = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_DEC = 4'd4;
  localparam logic [3:0] OP_ADD = 4'd5;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_INC = 4'd7;
  localparam logic [3:0] OP_SLL = 4'd8;
  localparam logic [3:0] OP_SRL = 4'd9;
  localparam logic [3:0] OP_SRA = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;

  localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);
  localparam logic [SHW:0] CNT_MUL = (SHW+1)'(WIDTH);

  state_t           state, next_state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] work_q;
  logic [SHW:0]     cnt_q;

  logic [WIDTH-1:0] arith_b, add_r, sub_r, one_res, shifted, iter_res;
  logic             add_c, sub_c, add_v, sub_v;
  logic             one_c, one_v, one_ill, one_iter;

  assign arith_b = (op_sel == OP_INC || op_sel == OP_DEC) ? WIDTH'(1) : op_b;
  assign {add_c, add_r} = {1'b0, op_a} + {1'b0, arith_b};
  assign {sub_c, sub_r} = {1'b0, op_a} - {1'b0, arith_b};
  // Bit WIDTH of the sign-extended sum is a[MSB]^b[MSB]^carry; its xor with the result MSB is overflow.
  assign add_v = op_a[WIDTH-1] ^ arith_b[WIDTH-1] ^ add_c ^ add_r[WIDTH-1];
  assign sub_v = op_a[WIDTH-1] ^ arith_b[WIDTH-1] ^ sub_c ^ sub_r[WIDTH-1];

  always_comb begin
    one_res  = '0;
    one_c    = 1'b0;
    one_v    = 1'b0;
    one_ill  = 1'b0;
    one_iter = 1'b0;
    case (op_sel)
      OP_NOT: one_res = ~op_a;
      OP_AND: one_res = op_a & op_b;
      OP_XOR: one_res = op_a ^ op_b;
      OP_OR:  one_res = op_a | op_b;
      OP_ADD, OP_INC: begin
        one_res = add_r;
        one_c   = add_c;
        one_v   = add_v;
      end
      OP_SUB, OP_DEC: begin
        one_res = sub_r;
        one_c   = sub_c;
        one_v   = sub_v;
      end
      OP_SLL, OP_SRL, OP_SRA: begin
        one_res  = op_a;
        one_iter = (op_b[SHW-1:0] != '0);
      end
`ifdef ALU_SEQ_MUL_EN
      OP_MUL: one_iter = 1'b1;
`endif
      default: one_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = one_iter ? BUSY : DONE;
      BUSY:    if (cnt_q == CNT_ONE) next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // The multiplier operand shifts right exactly like SRL, so MUL shares that path.
  always_comb begin
    shifted = work_q;
    case (op_q)
      OP_SLL:         shifted = {work_q[WIDTH-2:0], 1'b0};
      OP_SRL, OP_MUL: shifted = {1'b0, work_q[WIDTH-1:1]};
      OP_SRA:         shifted = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      default:        shifted = work_q;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] acc_q, mcand_q, acc_next;
  assign acc_next = work_q[0] ? acc_q + mcand_q : acc_q;
  assign iter_res = (op_q == OP_MUL) ? acc_next : shifted;
`else
  assign iter_res = shifted;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      res     <= '0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      flag_v  <= 1'b0;
      illegal <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      acc_q   <= '0;
      mcand_q <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_q <= op_sel;
          if (one_iter) begin
            work_q <= op_a;
            cnt_q  <= {1'b0, op_b[SHW-1:0]};
`ifdef ALU_SEQ_MUL_EN
            acc_q   <= '0;
            mcand_q <= op_a;
            if (op_sel == OP_MUL) begin
              work_q <= op_b;
              cnt_q  <= CNT_MUL;
            end
`endif
          end else begin
            res     <= one_res;
            flag_z  <= (one_res == '0);
            flag_c  <= one_c;
            flag_v  <= one_v;
            illegal <= one_ill;
          end
        end
        BUSY: begin
          work_q <= shifted;
          cnt_q  <= cnt_q - CNT_ONE;
`ifdef ALU_SEQ_MUL_EN
          acc_q   <= acc_next;
          mcand_q <= {mcand_q[WIDTH-2:0], 1'b0};
`endif
          if (cnt_q == CNT_ONE) begin
            res     <= iter_res;
            flag_z  <= (iter_res == '0);
            flag_c  <= 1'b0;
            flag_v  <= 1'b0;
            illegal <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized self-checking bench for alu_seq against an arithmetic reference model.
// Expectations for opcode 11 follow ALU_SEQ_MUL_EN, the same macro that configures the design.
module tb_alu_seq;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [3:0]       op_sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             flag_z, flag_c, flag_v, illegal;

  int assertCount = 0;
  int failCount   = 0;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_sel(op_sel), .out_valid(out_valid),
    .out_ready(out_ready), .res(res), .flag_z(flag_z), .flag_c(flag_c),
    .flag_v(flag_v), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic bit signedOvf(input longint s);
    return (s > 64'sd2147483647) || (s < -(64'sd2147483648));
  endfunction

  // Reference: plain 64-bit arithmetic, latency from the shift amount or multiplier width.
  function automatic void refModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic [3:0] flags, output int lat);
    longint ua, ub, sa, sb, wide;
    int     amt;
    logic   c, v, ill;
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    amt = int'(b[4:0]);
    r = '0; c = 1'b0; v = 1'b0; ill = 1'b0; lat = 1;
    case (op)
      4'd0: r = ~a;
      4'd1: r = a & b;
      4'd2: r = a ^ b;
      4'd3: r = a | b;
      4'd4: begin wide = ua - 1;  r = wide[31:0]; c = (ua < 1);  v = signedOvf(sa - 1);  end
      4'd5: begin wide = ua + ub; r = wide[31:0]; c = wide[32];  v = signedOvf(sa + sb); end
      4'd6: begin wide = ua - ub; r = wide[31:0]; c = (ua < ub); v = signedOvf(sa - sb); end
      4'd7: begin wide = ua + 1;  r = wide[31:0]; c = wide[32];  v = signedOvf(sa + 1);  end
      4'd8:  begin r = a << amt; lat = amt + 1; end
      4'd9:  begin r = a >> amt; lat = amt + 1; end
      4'd10: begin r = 32'($signed(a) >>> amt); lat = amt + 1; end
`ifdef ALU_SEQ_MUL_EN
      4'd11: begin wide = ua * ub; r = wide[31:0]; lat = WIDTH + 1; end
`endif
      default: ill = 1'b1;
    endcase
    flags = {(r == 32'd0), c, v, ill};
  endfunction

  // Issue one operation, measure its latency, hold it under backpressure, then release it.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input int hold, input string tag);
    logic [31:0] expRes;
    logic [3:0]  expFlags;
    int          expLat, lat, w;
    refModel(op, a, b, expRes, expFlags, expLat);
    w = 0;
    while (!in_ready && w < 200) begin
      @(posedge clk); #1; w++;
    end
    if (!in_ready) checkOutput({tag, " ready-timeout"}, 64'(in_ready), 64'd1);
    op_sel = op; op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a = $urandom; op_b = $urandom; op_sel = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    checkOutput({tag, " latency"}, 64'(lat), 64'(expLat));
    checkOutput({tag, " res"}, 64'(res), 64'(expRes));
    checkOutput({tag, " zcvi"}, 64'({flag_z, flag_c, flag_v, illegal}), 64'(expFlags));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; op_sel = 4'($urandom); op_a = $urandom; op_b = $urandom;
      @(posedge clk); #1;
      checkOutput({tag, " held"}, 64'({res, flag_z, flag_c, flag_v, illegal, out_valid, in_ready}),
                  64'({expRes, expFlags, 2'b10}));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, " released"}, 64'({in_ready, out_valid}), 64'(2'b10));
  endtask

  function automatic logic [31:0] pickVal();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; op_sel = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset state", 64'({in_ready, out_valid, res, flag_z, flag_c, flag_v, illegal}),
                64'({2'b10, 32'd0, 4'b0000}));
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(4'd5,  32'h7FFF_FFFF, 32'h0000_0001, 0, "add ovf");
    applyStimulus(4'd6,  32'h0000_0000, 32'h0000_0001, 0, "sub borrow");
    applyStimulus(4'd10, 32'h8000_0000, 32'd4,         0, "sra 4");
    applyStimulus(4'd8,  32'h1234_5678, 32'd0,         0, "sll 0");
    applyStimulus(4'd9,  32'h8000_0000, 32'd31,        0, "srl 31");
    applyStimulus(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mul");
    applyStimulus(4'd2,  32'hF0F0_F0F0, 32'hFFFF_FFFF, 10, "xor backpressure");
    applyStimulus(4'd13, 32'h1111_1111, 32'h2222_2222, 0, "illegal 13");
    applyStimulus(4'd7,  32'hFFFF_FFFF, 32'd0,         0, "inc wrap");
    applyStimulus(4'd4,  32'h8000_0000, 32'd0,         0, "dec ovf");
    applyStimulus(4'd0,  32'h0000_0000, 32'h0,         0, "not zero");

    // Reset in the middle of a long operation must discard it and clear outputs at once.
`ifdef ALU_SEQ_MUL_EN
    op_sel = 4'd11; op_b = 32'h0000_0003;
`else
    op_sel = 4'd9;  op_b = 32'd31;
`endif
    op_a = 32'hDEAD_BEEF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("busy before reset", 64'({in_ready, out_valid, res}), 64'({2'b00, 32'hFFFF_FFFF}));
    rst_n = 1'b0;
    #1;
    checkOutput("async reset", 64'({in_ready, out_valid, res, flag_z, flag_c, flag_v, illegal}),
                64'({2'b10, 32'd0, 4'b0000}));
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("after reset", 64'({in_ready, out_valid}), 64'(2'b10));

    repeat (60) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom);
      a  = pickVal();
      b  = pickVal();
      applyStimulus(op, a, b, $urandom_range(0, 3), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
